// File: rtl/dice_roller.sv
// Dice roller: debounced roll button, two spinning dice, valid/ready sum hand-off and 7-seg drive.
// Define DICE_LFSR_EN to draw the dice from an 8-bit LFSR instead of the cascaded spin counters.
module dice_roller #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       roll,
  input  logic       sum_ready,
  output logic       sum_valid,
  output logic [3:0] sum,
  output logic [2:0] die1,
  output logic [2:0] die2,
  output logic [6:0] disp1,
  output logic [6:0] disp2,
  output logic       rolling
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    PRESENT = 2'd2
  } state_t;

  function automatic logic [6:0] seg7(input logic [2:0] v);
    logic [6:0] s;
    case (v)
      3'd1:    s = 7'b0000110;
      3'd2:    s = 7'b1011011;
      3'd3:    s = 7'b1001111;
      3'd4:    s = 7'b1100110;
      3'd5:    s = 7'b1101101;
      3'd6:    s = 7'b1111101;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  logic         sync1_r;
  logic         sync2_r;
  logic         db_level_r;
  logic [CNT_W-1:0] db_cnt_r;
  logic         flip_s;
  logic         press_s;
  logic         release_s;
  logic [2:0]   pick_a_s;
  logic [2:0]   pick_b_s;
  state_t       state_r;

  // Synchronize the raw button and debounce it into a clean level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      db_level_r <= 1'b0;
      db_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      sync1_r <= roll;
      sync2_r <= sync1_r;
      if (sync2_r != db_level_r) begin
        if (db_cnt_r == CNT_LAST) begin
          db_level_r <= sync2_r;
          db_cnt_r   <= {CNT_W{1'b0}};
        end else begin
          db_cnt_r <= db_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        db_cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

  // Press/release fire on the very edge the debounced level flips.
  always_comb begin
    flip_s    = 1'b0;
    press_s   = 1'b0;
    release_s = 1'b0;
    if ((sync2_r != db_level_r) && (db_cnt_r == CNT_LAST)) begin
      flip_s = 1'b1;
    end else begin
      flip_s = 1'b0;
    end
    press_s   = flip_s & ~db_level_r;
    release_s = flip_s &  db_level_r;
  end

`ifdef DICE_LFSR_EN
  logic [7:0] lfsr_r;

  function automatic logic [2:0] mod6_plus1(input logic [3:0] v);
    logic [3:0] t;
    t = (v % 4'd6) + 4'd1;
    return t[2:0];
  endfunction

  // Free-running x^8+x^6+x^5+x^4+1 Fibonacci LFSR.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_r <= 8'h01;
    end else begin
      lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
    end
  end

  // Map LFSR nibbles onto 1..6.
  always_comb begin
    pick_a_s = mod6_plus1(lfsr_r[3:0]);
    pick_b_s = mod6_plus1(lfsr_r[7:4]);
  end
`else
  logic [2:0] spin_a_r;
  logic [2:0] spin_b_r;

  // Cascaded spin counters; B steps only when A wraps, and the release edge is not a spin.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      spin_a_r <= 3'd1;
      spin_b_r <= 3'd1;
    end else if ((state_r == ROLLING) && !release_s) begin
      if (spin_a_r == 3'd6) begin
        spin_a_r <= 3'd1;
        spin_b_r <= (spin_b_r == 3'd6) ? 3'd1 : (spin_b_r + 3'd1);
      end else begin
        spin_a_r <= spin_a_r + 3'd1;
      end
    end else begin
      spin_a_r <= spin_a_r;
      spin_b_r <= spin_b_r;
    end
  end

  // Dice are taken straight from the spin counters.
  always_comb begin
    pick_a_s = spin_a_r;
    pick_b_s = spin_b_r;
  end
`endif

  // Roll FSM with registered handshake, dice and display outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      sum_valid <= 1'b0;
      sum       <= 4'd0;
      die1      <= 3'd1;
      die2      <= 3'd1;
      disp1     <= 7'b0000000;
      disp2     <= 7'b0000000;
      rolling   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (press_s) begin
            state_r <= ROLLING;
            rolling <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        ROLLING: begin
          if (release_s) begin
            die1      <= pick_a_s;
            die2      <= pick_b_s;
            sum       <= {1'b0, pick_a_s} + {1'b0, pick_b_s};
            disp1     <= seg7(pick_a_s);
            disp2     <= seg7(pick_b_s);
            sum_valid <= 1'b1;
            rolling   <= 1'b0;
            state_r   <= PRESENT;
          end else begin
            state_r <= ROLLING;
          end
        end
        PRESENT: begin
          // Button activity here is deliberately dropped, not queued.
          if (sum_ready) begin
            sum_valid <= 1'b0;
            state_r   <= IDLE;
          end else begin
            state_r <= PRESENT;
          end
        end
        default: begin
          state_r   <= IDLE;
          sum_valid <= 1'b0;
          rolling   <= 1'b0;
        end
      endcase
    end
  end

endmodule
